// File: rtl/alu_pkg.sv
// Shared opcode, unit-group and FSM state encodings for the ALU command front end.
package alu_pkg;

  // Opcode bits [3:2] select the ALU unit, bits [1:0] the operation within it
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_CMPLT = 4'b1000;
  localparam logic [3:0] OP_CMPEQ = 4'b1001;
  localparam logic [3:0] OP_CMPGT = 4'b1010;
  localparam logic [3:0] OP_CMPGE = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;
  localparam logic [3:0] OP_SHL   = 4'b1101;
  localparam logic [3:0] OP_SHR   = 4'b1110;
  localparam logic [3:0] OP_ROL   = 4'b1111;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_CMP   = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding {a, b, fun}; head is visible combinationally.
module alu_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_a,
  input  logic [WIDTH-1:0]           i_b,
  input  logic [3:0]                 i_fun,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_a,
  output logic [WIDTH-1:0]           o_b,
  output logic [3:0]                 o_fun,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * WIDTH + 4;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  // A full FIFO refuses a push even if the head leaves on the same edge
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign {o_a, o_b, o_fun} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= {i_a, i_b, i_fun};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued commands one at a time into the ALU, waits its fixed latency and
// returns the result of the addressed unit on a backpressured response port.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_fun,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_fun,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic [1:0]       dbg_state
);

  localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_alu_a;
  logic [WIDTH-1:0]       r_alu_b;
  logic [3:0]             r_alu_fun;
  logic [WIDTH-1:0]       r_rsp_data;
  logic [3:0]             r_rsp_fun;
  logic                   r_rsp_err;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [WIDTH-1:0]       w_head_a;
  logic [WIDTH-1:0]       w_head_b;
  logic [3:0]             w_head_fun;
  logic [WIDTH-1:0]       w_sel_data;
  logic                   w_sel_flag;

  // Both ports transfer on an edge where valid && ready; a response stays
  // offered with unchanged payload until the consumer takes it.
  assign cmd_ready = rst && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = !w_empty &&
                     ((r_state == ST_IDLE) || (r_state == ST_RESP && rsp_ready));

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_fun   = r_rsp_fun;
  assign rsp_err   = r_rsp_err;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_fun   = r_alu_fun;
  assign busy      = (w_count != '0) || (r_state != ST_IDLE);
  assign dbg_state = r_state;

  alu_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_a     (cmd_a),
    .i_b     (cmd_b),
    .i_fun   (cmd_fun),
    .i_pop   (w_pop),
    .o_a     (w_head_a),
    .o_b     (w_head_b),
    .o_fun   (w_head_fun),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_sel_data = arith_out;
    w_sel_flag = arith_flag;
    case (r_alu_fun[3:2])
      GRP_LOGIC: begin w_sel_data = logic_out; w_sel_flag = logic_flag; end
      GRP_CMP:   begin w_sel_data = cmp_out;   w_sel_flag = cmp_flag;   end
      GRP_SHIFT: begin w_sel_data = shift_out; w_sel_flag = shift_flag; end
      default:   begin w_sel_data = arith_out; w_sel_flag = arith_flag; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_fun  <= '0;
      r_rsp_data <= '0;
      r_rsp_fun  <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pop) r_state <= ST_WAIT;
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_rsp_data <= w_sel_data;
            r_rsp_fun  <= r_alu_fun;
            r_rsp_err  <= ~w_sel_flag;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: if (rsp_ready) r_state <= w_pop ? ST_WAIT : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      // Popping from RESP skips IDLE so back-to-back results cost LATENCY+2 cycles
      if (w_pop) begin
        r_alu_a   <= w_head_a;
        r_alu_b   <= w_head_b;
        r_alu_fun <= w_head_fun;
        r_cnt     <= CNT_LOAD;
      end
    end
  end

endmodule
